// File: rtl/affine_addr_seq.sv
// ----------------------------------------------------------------------------
// affine_addr_seq
//
// Purpose:
//   Bounded 2D affine address walker. On start it latches its configuration
//   and streams addr = offset + x*x_stride + y*y_stride (x inner, y outer),
//   one address per accepted valid/ready beat. The final address is flagged
//   with last_o, and done_o pulses once after that beat has been accepted.
//   All address arithmetic wraps modulo 2^W.
//
// Ports:
//   clk_i           clock, everything on posedge
//   rst_i           synchronous active-high reset
//   cfg_offset_i    base address                     (W bits)
//   cfg_x_max_i     inner extent, number of x points (CW bits)
//   cfg_x_stride_i  address step per x               (W bits)
//   cfg_y_max_i     outer extent, number of y rows   (CW bits)
//   cfg_y_stride_i  address step per y               (W bits)
//   start_i         begin a walk, only seen in IDLE
//   abort_i         cancel a walk, only seen in RUN
//   busy_o          high in RUN or DONE
//   addr_o          current registered address
//   addr_valid_o    addr_o holds a beat
//   addr_ready_i    consumer takes the beat when valid & ready
//   last_o          addr_o is the final address of the walk
//   done_o          one-cycle pulse after the final beat is taken
// ----------------------------------------------------------------------------
module affine_addr_seq #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [W-1:0]  cfg_offset_i,
    input  logic [CW-1:0] cfg_x_max_i,
    input  logic [W-1:0]  cfg_x_stride_i,
    input  logic [CW-1:0] cfg_y_max_i,
    input  logic [W-1:0]  cfg_y_stride_i,
    input  logic          start_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic [W-1:0]  addr_o,
    output logic          addr_valid_o,
    input  logic          addr_ready_i,
    output logic          last_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;

    logic [W-1:0]  offset_q;
    logic [CW-1:0] x_max_q;
    logic [W-1:0]  x_stride_q;
    logic [CW-1:0] y_max_q;
    logic [W-1:0]  y_stride_q;

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic [W-1:0]  x_acc_q, x_acc_d;
    logic [W-1:0]  y_acc_q, y_acc_d;

    logic [W-1:0]  addr_q, addr_d;
    logic          valid_q;
    logic          last_q, last_d;
    logic          done_q;

    logic          x_wrap;
    logic          beat;

    // Next walk position, computed from the current one. Strides are kept
    // as running accumulators so the address needs only adders, never a
    // multiplier; the sum is registered once on the accepting edge.
    always_comb begin
        x_wrap  = (x_q == x_max_q - CW'(1));
        x_d     = x_wrap ? '0 : x_q + CW'(1);
        y_d     = x_wrap ? y_q + CW'(1) : y_q;
        x_acc_d = x_wrap ? '0 : x_acc_q + x_stride_q;
        y_acc_d = x_wrap ? y_acc_q + y_stride_q : y_acc_q;
        addr_d  = offset_q + x_acc_d + y_acc_d;
        last_d  = (x_d == x_max_q - CW'(1)) && (y_d == y_max_q - CW'(1));
        beat    = valid_q && addr_ready_i;
    end

    // Control FSM with all outputs registered. A zero extent on start skips
    // RUN entirely so no beat is ever issued. Abort wins over a same-cycle
    // transfer; the consumer still owns that beat, we simply stop after it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            offset_q   <= '0;
            x_max_q    <= '0;
            x_stride_q <= '0;
            y_max_q    <= '0;
            y_stride_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            x_acc_q    <= '0;
            y_acc_q    <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        offset_q   <= cfg_offset_i;
                        x_max_q    <= cfg_x_max_i;
                        x_stride_q <= cfg_x_stride_i;
                        y_max_q    <= cfg_y_max_i;
                        y_stride_q <= cfg_y_stride_i;
                        x_q        <= '0;
                        y_q        <= '0;
                        x_acc_q    <= '0;
                        y_acc_q    <= '0;
                        if ((cfg_x_max_i != '0) && (cfg_y_max_i != '0)) begin
                            state_q <= RUN;
                            addr_q  <= cfg_offset_i;
                            valid_q <= 1'b1;
                            last_q  <= (cfg_x_max_i == CW'(1)) && (cfg_y_max_i == CW'(1));
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (beat) begin
                        if (last_q) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            x_q     <= x_d;
                            y_q     <= y_d;
                            x_acc_q <= x_acc_d;
                            y_acc_q <= y_acc_d;
                            addr_q  <= addr_d;
                            last_q  <= last_d;
                        end
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign addr_o       = addr_q;
    assign addr_valid_o = valid_q;
    assign last_o       = last_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_affine_addr_seq.sv
// ----------------------------------------------------------------------------
// tb_affine_addr_seq
//
// Self-checking bench for affine_addr_seq. Inputs change and outputs are
// sampled on the falling edge. A per-cycle vector table covers the basic
// walk and a stalled walk; hand-written sequences cover zero extents, a
// single-point walk, address wrap, abort/restart, reset mid-walk and start
// while busy.
// ----------------------------------------------------------------------------
module tb_affine_addr_seq;

    logic        clk;
    logic        rst;
    logic [31:0] cfgOffset;
    logic [15:0] cfgXMax;
    logic [31:0] cfgXStride;
    logic [15:0] cfgYMax;
    logic [31:0] cfgYStride;
    logic        start;
    logic        abort;
    logic        busy;
    logic [31:0] addr;
    logic        addrValid;
    logic        addrReady;
    logic        last;
    logic        done;

    int total;
    int bad;

    typedef struct {
        logic        start;
        logic        ready;
        logic        chkAddr;
        logic [31:0] expAddr;
        logic        expValid;
        logic        expLast;
        logic        expDone;
        logic        expBusy;
    } vec_t;

    vec_t        vecs[23];
    logic [31:0] wrapExp[4];
    logic [31:0] tailExp[5];

    affine_addr_seq #(.W(32), .CW(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_offset_i   (cfgOffset),
        .cfg_x_max_i    (cfgXMax),
        .cfg_x_stride_i (cfgXStride),
        .cfg_y_max_i    (cfgYMax),
        .cfg_y_stride_i (cfgYStride),
        .start_i        (start),
        .abort_i        (abort),
        .busy_o         (busy),
        .addr_o         (addr),
        .addr_valid_o   (addrValid),
        .addr_ready_i   (addrReady),
        .last_o         (last),
        .done_o         (done)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of control inputs and land on the next falling edge.
    task automatic applyStimulus(input logic st, input logic rd, input logic ab);
        start     = st;
        addrReady = rd;
        abort     = ab;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Single comparison with bookkeeping.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare the four control outputs at once.
    task automatic checkFlags(input string tag, input logic v, input logic l,
                              input logic d, input logic b);
        checkOutput({tag, ".valid"}, 32'(addrValid), 32'(v));
        checkOutput({tag, ".last"},  32'(last),      32'(l));
        checkOutput({tag, ".done"},  32'(done),      32'(d));
        checkOutput({tag, ".busy"},  32'(busy),      32'(b));
    endtask

    task automatic setCfg(input logic [31:0] off, input logic [15:0] xm, input logic [31:0] xs,
                          input logic [15:0] ym, input logic [31:0] ys);
        cfgOffset  = off;
        cfgXMax    = xm;
        cfgXStride = xs;
        cfgYMax    = ym;
        cfgYStride = ys;
    endtask

    function automatic vec_t mk(input logic st, input logic rd, input logic ca,
                                input logic [31:0] a, input logic v, input logic l,
                                input logic d, input logic b);
        vec_t r;
        r.start    = st;
        r.ready    = rd;
        r.chkAddr  = ca;
        r.expAddr  = a;
        r.expValid = v;
        r.expLast  = l;
        r.expDone  = d;
        r.expBusy  = b;
        return r;
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        // Walk of offset=100, 3x2, strides 4/64: 100,104,108,164,168,172.
        // Each row: check outputs now, then drive start/ready for one cycle.
        vecs[0]  = mk(1, 1, 0, 0,   0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 100, 1, 0, 0, 1);
        vecs[2]  = mk(0, 1, 1, 104, 1, 0, 0, 1);
        vecs[3]  = mk(0, 1, 1, 108, 1, 0, 0, 1);
        vecs[4]  = mk(0, 1, 1, 164, 1, 0, 0, 1);
        vecs[5]  = mk(0, 1, 1, 168, 1, 0, 0, 1);
        vecs[6]  = mk(0, 1, 1, 172, 1, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0,   0, 0, 1, 1);
        // Same walk with ready pattern 1,0,0,1,0,0,1,1,0,1,0,1.
        vecs[8]  = mk(1, 1, 0, 0,   0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 1, 100, 1, 0, 0, 1);
        vecs[10] = mk(0, 0, 1, 104, 1, 0, 0, 1);
        vecs[11] = mk(0, 0, 1, 104, 1, 0, 0, 1);
        vecs[12] = mk(0, 1, 1, 104, 1, 0, 0, 1);
        vecs[13] = mk(0, 0, 1, 108, 1, 0, 0, 1);
        vecs[14] = mk(0, 0, 1, 108, 1, 0, 0, 1);
        vecs[15] = mk(0, 1, 1, 108, 1, 0, 0, 1);
        vecs[16] = mk(0, 1, 1, 164, 1, 0, 0, 1);
        vecs[17] = mk(0, 0, 1, 168, 1, 0, 0, 1);
        vecs[18] = mk(0, 1, 1, 168, 1, 0, 0, 1);
        vecs[19] = mk(0, 0, 1, 172, 1, 1, 0, 1);
        vecs[20] = mk(0, 1, 1, 172, 1, 1, 0, 1);
        vecs[21] = mk(0, 0, 0, 0,   0, 0, 1, 1);
        vecs[22] = mk(0, 0, 0, 0,   0, 0, 0, 0);

        wrapExp[0] = 32'hFFFF_FFF0;
        wrapExp[1] = 32'hFFFF_FFF8;
        wrapExp[2] = 32'h0000_0000;
        wrapExp[3] = 32'h0000_0008;

        tailExp[0] = 104;
        tailExp[1] = 108;
        tailExp[2] = 164;
        tailExp[3] = 168;
        tailExp[4] = 172;

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        addrReady = 1'b0;
        setCfg(100, 3, 4, 2, 64);
        @(negedge clk);
        applyStimulus(0, 0, 0);

        // Reset state.
        checkFlags("reset", 0, 0, 0, 0);
        checkOutput("reset.addr", addr, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0);

        // Table: plain walk and stalled walk.
        for (int i = 0; i < 23; i++) begin
            checkFlags($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expLast,
                       vecs[i].expDone, vecs[i].expBusy);
            if (vecs[i].chkAddr)
                checkOutput($sformatf("vec%0d.addr", i), addr, vecs[i].expAddr);
            applyStimulus(vecs[i].start, vecs[i].ready, 1'b0);
        end

        // Zero x extent, then zero y extent: straight to DONE, no beat.
        setCfg(100, 0, 4, 2, 64);
        applyStimulus(1, 1, 0);
        checkFlags("zeroX.c1", 0, 0, 1, 1);
        applyStimulus(0, 1, 0);
        checkFlags("zeroX.c2", 0, 0, 0, 0);
        setCfg(100, 3, 4, 0, 64);
        applyStimulus(1, 1, 0);
        checkFlags("zeroY.c1", 0, 0, 1, 1);
        applyStimulus(0, 1, 0);
        checkFlags("zeroY.c2", 0, 0, 0, 0);

        // Single-point walk: first beat is already last.
        setCfg(7, 1, 4, 1, 64);
        applyStimulus(1, 0, 0);
        checkFlags("single.beat", 1, 1, 0, 1);
        checkOutput("single.addr", addr, 7);
        applyStimulus(0, 1, 0);
        checkFlags("single.done", 0, 0, 1, 1);
        applyStimulus(0, 0, 0);

        // Address wrap across 2^32.
        setCfg(32'hFFFF_FFF0, 4, 8, 1, 5);
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wrap%0d.addr", i), addr, wrapExp[i]);
            checkFlags($sformatf("wrap%0d", i), 1, (i == 3), 0, 1);
            applyStimulus(0, 1, 0);
        end
        checkFlags("wrap.done", 0, 0, 1, 1);
        applyStimulus(0, 0, 0);

        // Abort alongside the transfer of the second beat, then restart.
        setCfg(100, 3, 4, 2, 64);
        applyStimulus(1, 0, 0);
        checkOutput("abort.b0", addr, 100);
        applyStimulus(0, 1, 0);
        checkOutput("abort.b1", addr, 104);
        applyStimulus(0, 1, 1);
        checkFlags("abort.c1", 0, 0, 0, 0);
        applyStimulus(0, 1, 1);
        checkFlags("abort.c2", 0, 0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("restart.b0", addr, 100);
        checkFlags("restart.b0", 1, 0, 0, 1);
        applyStimulus(0, 1, 0);
        checkOutput("restart.b1", addr, 104);

        // Synchronous reset mid-walk: everything back to zero, no done.
        rst = 1'b1;
        applyStimulus(0, 1, 0);
        checkFlags("midRst", 0, 0, 0, 0);
        checkOutput("midRst.addr", addr, 0);
        rst = 1'b0;
        applyStimulus(0, 1, 0);
        checkFlags("postRst", 0, 0, 0, 0);

        // Start while busy with a new config must not disturb the walk.
        applyStimulus(1, 0, 0);
        checkOutput("busyStart.b0", addr, 100);
        setCfg(5000, 9, 1, 9, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0);
            checkOutput($sformatf("busyStart.b%0d", i + 1), addr, tailExp[i]);
            checkFlags($sformatf("busyStart.b%0d", i + 1), 1, (i == 4), 0, 1);
        end
        applyStimulus(0, 1, 0);
        checkFlags("busyStart.done", 0, 0, 1, 1);
        applyStimulus(0, 0, 0);
        checkFlags("busyStart.idle", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
